// File: rtl/column_bar_plotter_if.sv
// Bundles the plotter's control handshake, buffer read port and VGA pixel port.
// master: plotter side; slave: sequencer, y buffer and VGA adapter side.
interface column_bar_plotter_if;
  logic       start;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  rd_data,
    output rd_en,
    output rd_addr,
    output vga_x,
    output vga_y,
    output vga_colour,
    output vga_plot,
    output busy,
    output done
  );

  modport slave (
    output start,
    output rd_data,
    input  rd_en,
    input  rd_addr,
    input  vga_x,
    input  vga_y,
    input  vga_colour,
    input  vga_plot,
    input  busy,
    input  done
  );
endinterface

// File: rtl/column_bar_plotter.sv
// Sweeps columns 0..WIDTH-1, reads each column's y and plots a BAR_H-pixel segment at it.
// Optional macro PLOTTER_CLEAR_EN blanks each column in BG_COLOUR before its segment.
module column_bar_plotter #(
  parameter int unsigned WIDTH     = 160,
  parameter int unsigned HEIGHT    = 120,
  parameter int unsigned BAR_H     = 4,
  parameter logic [2:0]  FG_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 resetn,
  column_bar_plotter_if.master bus
);

  localparam logic [6:0] YMax    = 7'(HEIGHT - BAR_H);
  localparam logic [7:0] XLast   = 8'(WIDTH - 1);
  localparam logic [6:0] BarLast = 7'(BAR_H - 1);
`ifdef PLOTTER_CLEAR_EN
  localparam logic [6:0] RowLast = 7'(HEIGHT - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
`ifdef PLOTTER_CLEAR_EN
    StClear,
`endif
    StDraw,
    StDone
  } state_e;

  state_e     r_state, w_state_next;
  logic [7:0] r_x, w_x_next;
  logic [6:0] r_row, w_row_next;
  logic [6:0] r_ybase, w_ybase_next;

  logic       r_rd_en, w_rd_en_next;
  logic [7:0] r_rd_addr, w_rd_addr_next;
  logic [7:0] r_vga_x, w_vga_x_next;
  logic [6:0] r_vga_y, w_vga_y_next;
  logic [2:0] r_vga_colour, w_vga_colour_next;
  logic       r_vga_plot, w_vga_plot_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_x          <= '0;
      r_row        <= '0;
      r_ybase      <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_x          <= w_x_next;
      r_row        <= w_row_next;
      r_ybase      <= w_ybase_next;
      r_rd_en      <= w_rd_en_next;
      r_rd_addr    <= w_rd_addr_next;
      r_vga_x      <= w_vga_x_next;
      r_vga_y      <= w_vga_y_next;
      r_vga_colour <= w_vga_colour_next;
      r_vga_plot   <= w_vga_plot_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
    end
  end

  // Next state and counters.
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_row_next   = r_row;
    w_ybase_next = r_ybase;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_x_next     = '0;
          w_state_next = StFetch;
        end
      end
      StFetch: begin
        w_state_next = StWait;
      end
      StWait: begin
        // Clamp keeps the whole segment on screen, including rd_data[7] set.
        w_ybase_next = (bus.rd_data > {1'b0, YMax}) ? YMax : bus.rd_data[6:0];
        w_row_next   = '0;
`ifdef PLOTTER_CLEAR_EN
        w_state_next = StClear;
`else
        w_state_next = StDraw;
`endif
      end
`ifdef PLOTTER_CLEAR_EN
      StClear: begin
        if (r_row == RowLast) begin
          w_row_next   = '0;
          w_state_next = StDraw;
        end else begin
          w_row_next = r_row + 7'd1;
        end
      end
`endif
      StDraw: begin
        if (r_row == BarLast) begin
          if (r_x == XLast) begin
            w_state_next = StDone;
          end else begin
            w_x_next     = r_x + 8'd1;
            w_state_next = StFetch;
          end
        end else begin
          w_row_next = r_row + 7'd1;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    w_rd_en_next      = (w_state_next == StFetch);
    w_rd_addr_next    = r_rd_addr;
    w_vga_plot_next   = 1'b0;
    w_vga_x_next      = r_vga_x;
    w_vga_y_next      = r_vga_y;
    w_vga_colour_next = BG_COLOUR;
    w_busy_next       = (w_state_next != StIdle);
    w_done_next       = (w_state_next == StDone);

    if (w_state_next == StFetch) begin
      w_rd_addr_next = w_x_next;
    end
    if (w_state_next == StDraw) begin
      w_vga_plot_next   = 1'b1;
      w_vga_x_next      = w_x_next;
      w_vga_y_next      = w_ybase_next + w_row_next;
      w_vga_colour_next = FG_COLOUR;
    end
`ifdef PLOTTER_CLEAR_EN
    if (w_state_next == StClear) begin
      w_vga_plot_next = 1'b1;
      w_vga_x_next    = w_x_next;
      w_vga_y_next    = w_row_next;
    end
`endif
  end

  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.vga_plot   = r_vga_plot;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
